fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction buffer between the fetch stage and decode.
//  Captures {pc, inst, error} tuples produced by fetch and holds up to DEPTH entries.
//  Presents the entries in order to decode over a valid/ready handshake.
//  Decouples decode stalls from the fetch PC stream.
//  Supports a flush used on branch redirect and trap redirect.
// PARAMETERS
//  DEPTH  4  number of entries; power of two, >= 2
//  XLEN   32 width of pc and inst fields
// PORTS
//  clk        in   1     clock; all state updates on posedge
//  rst        in   1     synchronous, active-high reset
//  flush      in   1     discard all entries this cycle
//  in_valid   in   1     fetch presents a tuple
//  in_ready   out  1     queue can accept a tuple
//  in_pc      in   XLEN  pc of fetched instruction
//  in_inst    in   XLEN  fetched instruction word
//  in_error   in   1     fetch/icache error for this tuple
//  out_valid  out  1     head entry valid for decode
//  out_ready  in   1     decode consumes head entry
//  out_pc     out  XLEN  head pc
//  out_inst   out  XLEN  head instruction
//  out_error  out  1     head error flag
//  count      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Storage: circular array; rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
//    count is tracked separately, range 0..DEPTH.
//  - push = in_valid & in_ready.
//  - pop = out_valid & out_ready.
//  - in_ready = !rst & (count != DEPTH). It is combinational.
//    There is no same-cycle pass-through when full, even if a pop occurs.
//  - out_valid = (count != 0).
//  - out_pc, out_inst and out_error equal entry[rd_ptr] when out_valid = 1.
//    They are 0 when out_valid = 0.
//  - Latency: a tuple pushed in cycle N is visible on out_* in cycle N+1 at the earliest.
//    There is no bypass when the queue is empty.
//  - Order is strict FIFO. pc, inst and error travel together and are never reordered.
//  - Push and pop in the same cycle (0 < count < DEPTH):
//    * both pointers advance;
//    * count is unchanged.
//  - Push only: write at wr_ptr, wr_ptr+1, count+1.
//  - Pop only: rd_ptr+1, count-1.
//  - flush has priority over push and pop:
//    * rd_ptr, wr_ptr and count go to 0 next cycle;
//    * a push in the same cycle is dropped;
//    * out_valid = 0 in the next cycle.
//  - Reset:
//    * rd_ptr, wr_ptr and count are 0;
//    * out_valid = 0, out_* data = 0;
//    * in_ready = 0 while rst is high and 1 in the first cycle after.
//    Reset mid-operation discards all entries exactly like flush.
//  - The error flag is carried through unchanged.
//    The queue never drops or stalls on error=1.
//  - Storage array contents need no reset. Outputs must never expose unwritten entries.
// TESTING
//  - Reset:
//    * assert rst for 2 cycles, then release;
//    * required: out_valid=0, count=0, in_ready=0 during rst, in_ready=1 after.
//  - Single tuple:
//    * push pc=0x0, inst=0x00000013 with out_ready=0;
//    * next cycle: out_valid=1, out_pc=0x0, out_inst=0x00000013, count=1.
//  - Fill:
//    * push pc=0x0,0x4,0x8,0xC with out_ready=0;
//    * required: count=4, in_ready=0;
//    * a 5th push (pc=0x10) is not accepted;
//    * then drain with out_ready=1: pcs 0x0,0x4,0x8,0xC in order, then out_valid=0.
//  - Streaming:
//    * out_ready=1, push every cycle pc=0x0..0x3C;
//    * required: count stays 1 after the first cycle;
//    * all 16 pcs emerge in order, pointer wrap is exercised.
//  - Flush:
//    * with 3 entries queued, assert flush together with a push of pc=0x40;
//    * next cycle: count=0, out_valid=0;
//    * pc=0x40 never appears on the output.
//  - Error passthrough:
//    * push pc=0x8 with in_error=1 between two clean tuples;
//    * required: out_error=1 only when out_pc=0x8.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode instruction buffer
// Circular FIFO of {pc, inst, error} tuples with flush for branch/trap redirect.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_inst,
  input  logic                     in_error,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_inst,
  output logic                     out_error,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] r_pc_mem   [DEPTH];
  logic [XLEN-1:0] r_inst_mem [DEPTH];
  logic            r_err_mem  [DEPTH];

  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic            w_wr_en;

  assign in_ready  = !rst && (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  // flush wins: a push in the flush cycle must not land in storage
  assign w_wr_en   = w_push && !flush;

  // Data outputs are gated so stale or unwritten slots are never visible
  assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr]   : '0;
  assign out_inst  = out_valid ? r_inst_mem[r_rd_ptr] : '0;
  assign out_error = out_valid ? r_err_mem[r_rd_ptr]  : 1'b0;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_pc_mem[r_wr_ptr]   <= in_pc;
      r_inst_mem[r_wr_ptr] <= in_inst;
      r_err_mem[r_wr_ptr]  <= in_error;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
// Model queue is updated on each posedge from the driven stimulus; DUT outputs are compared at negedge.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_error, out_ready;
  logic [XLEN-1:0] in_pc, in_inst;
  logic            in_ready, out_valid, out_error;
  logic [XLEN-1:0] out_pc, out_inst;
  logic [2:0]      count;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            err;
  } ent_t;

  ent_t            sb[$];
  logic [XLEN-1:0] obs[$];
  int              checks   = 0;
  int              failures = 0;
  bit              chk_en   = 1'b0;
  bit              seen_40  = 1'b0;
  bit              err_phase = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .in_error(in_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_error(out_error), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pop before push, push only if not full at the start of the cycle
  always @(posedge clk) begin
    bit m_push, m_pop;
    ent_t e;
    if (rst || flush) begin
      sb.delete();
    end else begin
      m_push = in_valid && (sb.size() != DEPTH);
      m_pop  = (sb.size() != 0) && out_ready;
      if (m_pop) void'(sb.pop_front());
      if (m_push) begin
        e.pc = in_pc; e.inst = in_inst; e.err = in_error;
        sb.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !rst && (sb.size() != DEPTH)});
      check("count", {29'd0, count}, sb.size());
      check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      if (sb.size() != 0) begin
        check("out_pc", out_pc, sb[0].pc);
        check("out_inst", out_inst, sb[0].inst);
        check("out_error", {31'd0, out_error}, {31'd0, sb[0].err});
      end else begin
        check("out_pc_idle", out_pc, '0);
        check("out_inst_idle", out_inst, '0);
        check("out_error_idle", {31'd0, out_error}, '0);
      end
      if (out_valid && out_pc == 32'h40) seen_40 = 1'b1;
      if (err_phase && out_valid)
        check("err_only_pc8", {31'd0, out_error}, {31'd0, out_pc == 32'h8});
      if (out_valid && out_ready) obs.push_back(out_pc);
    end
  end

  task automatic push(input logic [XLEN-1:0] pc, input logic err);
    in_valid = 1'b1; in_pc = pc; in_inst = pc ^ 32'h00000013; in_error = err;
    step();
    in_valid = 1'b0; in_error = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_error = 1'b0;
    out_ready = 1'b0; in_pc = '0; in_inst = '0;

    // reset for two cycles
    step();
    chk_en = 1'b1;
    check("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
    step();
    check("out_valid_rst", {31'd0, out_valid}, 32'd0);
    check("count_rst", {29'd0, count}, 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // single tuple, explicit inst 0x13
    in_valid = 1'b1; in_pc = 32'h0; in_inst = 32'h00000013;
    step();
    in_valid = 1'b0;
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_pc", out_pc, 32'h0);
    check("single_inst", out_inst, 32'h00000013);
    check("single_count", {29'd0, count}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    obs.delete();

    // fill to DEPTH, then try a fifth push
    for (int i = 0; i < 4; i++) push(32'(i * 4), 1'b0);
    check("fill_count", {29'd0, count}, 32'd4);
    check("fill_in_ready", {31'd0, in_ready}, 32'd0);
    push(32'h10, 1'b0);
    check("fill_5th_count", {29'd0, count}, 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b0;
    check("drain_len", obs.size(), 32'd4);
    for (int i = 0; i < 4 && i < obs.size(); i++) check("drain_order", obs[i], 32'(i * 4));
    check("drain_empty", {31'd0, out_valid}, 32'd0);
    obs.delete();

    // streaming with push and pop each cycle
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_pc = 32'(i * 4); in_inst = 32'(i * 4) ^ 32'h13; in_error = 1'b0;
      step();
      check("stream_count", {29'd0, count}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("stream_len", obs.size(), 32'd16);
    for (int i = 0; i < 16 && i < obs.size(); i++) check("stream_order", obs[i], 32'(i * 4));
    obs.delete();

    // flush together with a push of 0x40
    for (int i = 0; i < 3; i++) push(32'(32'h20 + i * 4), 1'b0);
    check("pre_flush_count", {29'd0, count}, 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h40; in_inst = 32'h40;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", {29'd0, count}, 32'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    step(); step();
    check("flush_no_0x40", {31'd0, seen_40}, 32'd0);
    out_ready = 1'b0;
    obs.delete();

    // error flag between two clean tuples
    push(32'h4, 1'b0);
    push(32'h8, 1'b1);
    push(32'hC, 1'b0);
    err_phase = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    err_phase = 1'b0;
    out_ready = 1'b0;
    check("err_drain_len", obs.size(), 32'd3);
    obs.delete();

    // reset mid-operation discards entries
    push(32'h100, 1'b0);
    push(32'h104, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_count", {29'd0, count}, 32'd0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
